// File: rtl/dmi_pkg.sv
// Shared types for the JTAG DTM: DMI op/status encodings, DTMCS layout and
// the DMI request/response payloads exchanged with the Debug Module.
package dmi_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_RSVD    = 2'h1,
        DTM_FAILED  = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_status_e;

    typedef struct packed {
        logic [31:18] zero1;
        logic         dmihardreset;
        logic         dmireset;
        logic         zero0;
        logic [14:12] idle;
        logic [11:10] dmistat;
        logic [9:4]   abits;
        logic [3:0]   version;
    } dtmcs_t;

    localparam logic [3:0] DtmVersion = 4'd1;

    // The address travels beside these structs because its width is a
    // per-instance parameter.
    typedef struct packed {
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_dr_ctrl.sv
// DTM data-register controller: DTMCS and DMI shift registers plus a
// one-outstanding-transaction DMI request/response sequencer, all on TCK.
module dmi_jtag_dr_ctrl
    import dmi_pkg::*;
#(
    parameter int unsigned AbitsWidth = 7,
    parameter logic [2:0]  IdleCycles = 3'd1
) (
    input  logic                  tck_i,
    input  logic                  trst_ni,
    input  logic                  dmi_clear_i,
    input  logic                  capture_i,
    input  logic                  shift_i,
    input  logic                  update_i,
    input  logic                  tdi_i,
    input  logic                  dtmcs_select_i,
    output logic                  dtmcs_tdo_o,
    input  logic                  dmi_select_i,
    output logic                  dmi_tdo_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [1:0]            dmi_req_op_o,
    output logic [31:0]           dmi_req_data_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [31:0]           dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_resp_i,
    output logic                  dmi_rst_no
);

    localparam int unsigned DmiWidth = AbitsWidth + 34;

    localparam logic [2:0] Idle      = 3'd0;
    localparam logic [2:0] Read      = 3'd1;
    localparam logic [2:0] WaitRead  = 3'd2;
    localparam logic [2:0] Write     = 3'd3;
    localparam logic [2:0] WaitWrite = 3'd4;

    logic [2:0]            state_q, state_d;
    dtmcs_t                dtmcs_q, dtmcs_val;
    logic [DmiWidth-1:0]   dmi_q;
    logic [AbitsWidth-1:0] addr_q;
    logic [31:0]           data_q;
    logic [1:0]            error_q, error_d;
    logic                  rst_nq;
    dmi_req_t              req;

    logic    dtmcs_update, dmi_reset, dmi_hard_reset;
    logic    dmi_capture, dmi_update, is_idle, busy_event, req_accept, resp_done, read_ok;
    logic    [1:0] resp_err;
    dtm_op_e upd_op;

    always_comb begin
        dtmcs_val         = '0;
        dtmcs_val.idle    = IdleCycles;
        dtmcs_val.dmistat = error_q;
        dtmcs_val.abits   = 6'(AbitsWidth);
        dtmcs_val.version = DtmVersion;
    end

    assign dtmcs_update   = update_i & dtmcs_select_i;
    assign dmi_reset      = dtmcs_update & dtmcs_q.dmireset;
    assign dmi_hard_reset = dtmcs_update & dtmcs_q.dmihardreset;

    assign is_idle     = (state_q == Idle);
    assign dmi_capture = capture_i & dmi_select_i;
    assign dmi_update  = update_i & dmi_select_i;
    assign busy_event  = (dmi_capture | dmi_update) & ~is_idle;
    assign req_accept  = dmi_update & is_idle & (error_q == DTM_SUCCESS);
    assign upd_op      = dtm_op_e'(dmi_q[1:0]);

    assign resp_done = dmi_resp_valid_i & dmi_resp_ready_o;
    assign read_ok   = resp_done & (state_q == WaitRead) & (dmi_resp_resp_i == DTM_SUCCESS)
                     & ~dmi_hard_reset;
    // The reserved status is reported to the debugger as a failure.
    assign resp_err  = (dmi_resp_resp_i == DTM_RSVD) ? DTM_FAILED : dmi_resp_resp_i;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle: begin
                if (req_accept && upd_op == DTM_READ)  state_d = Read;
                if (req_accept && upd_op == DTM_WRITE) state_d = Write;
            end
            Read:      if (dmi_req_ready_i)  state_d = WaitRead;
            Write:     if (dmi_req_ready_i)  state_d = WaitWrite;
            WaitRead,
            WaitWrite: if (dmi_resp_valid_i) state_d = Idle;
            default:   state_d = Idle;
        endcase
        if (dmi_hard_reset) state_d = Idle;
    end

    // Sticky status: it only ever rises until an explicit reset clears it.
    always_comb begin
        error_d = error_q;
        if (resp_done && resp_err > error_d) error_d = resp_err;
        if (busy_event)                      error_d = DTM_BUSY;
        if (dmi_reset || dmi_hard_reset)     error_d = DTM_SUCCESS;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= Idle;
            dtmcs_q <= '0;
            dmi_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= '0;
            rst_nq  <= 1'b1;
        end else if (dmi_clear_i) begin
            state_q <= Idle;
            dtmcs_q <= '0;
            dmi_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            error_q <= '0;
            rst_nq  <= 1'b1;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            rst_nq  <= ~dmi_hard_reset;
            if (dtmcs_select_i) begin
                if (capture_i)    dtmcs_q <= dtmcs_val;
                else if (shift_i) dtmcs_q <= dtmcs_t'({tdi_i, dtmcs_q[31:1]});
            end
            if (dmi_select_i) begin
                if (capture_i)    dmi_q <= {addr_q, data_q, is_idle ? error_q : DTM_BUSY};
                else if (shift_i) dmi_q <= {tdi_i, dmi_q[DmiWidth-1:1]};
            end
            if (req_accept) begin
                addr_q <= dmi_q[DmiWidth-1:34];
                data_q <= dmi_q[33:2];
            end else if (read_ok) begin
                data_q <= dmi_resp_data_i;
            end
        end
    end

    always_comb begin
        req.data = data_q;
        case (state_q)
            Read, WaitRead:   req.op = DTM_READ;
            Write, WaitWrite: req.op = DTM_WRITE;
            default:          req.op = DTM_NOP;
        endcase
    end

    assign dmi_req_valid_o  = (state_q == Read) | (state_q == Write);
    assign dmi_resp_ready_o = (state_q == WaitRead) | (state_q == WaitWrite);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_op_o     = req.op;
    assign dmi_req_data_o   = req.data;
    assign dmi_rst_no       = rst_nq;
    assign dtmcs_tdo_o      = dtmcs_q[0];
    assign dmi_tdo_o        = dmi_q[0];

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Directed bench for dmi_jtag_dr_ctrl: drives TAP strobes and a DM model by
// hand and compares against hand-computed values.
module tb_dmi_jtag_dr_ctrl;

    logic        tck = 1'b0;
    logic        trst_n, dmi_clear, capture, shift, update, tdi;
    logic        dtmcs_select, dmi_select, dtmcs_tdo, dmi_tdo;
    logic        req_valid, req_ready, resp_valid, resp_ready, rst_n_out;
    logic [6:0]  req_addr;
    logic [1:0]  req_op, resp_resp;
    logic [31:0] req_data, resp_data;

    logic [31:0] d32;
    logic [40:0] d41;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 tck = ~tck;

    dmi_jtag_dr_ctrl dut (
        .tck_i            (tck),
        .trst_ni          (trst_n),
        .dmi_clear_i      (dmi_clear),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .dtmcs_select_i   (dtmcs_select),
        .dtmcs_tdo_o      (dtmcs_tdo),
        .dmi_select_i     (dmi_select),
        .dmi_tdo_o        (dmi_tdo),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_addr_o   (req_addr),
        .dmi_req_op_o     (req_op),
        .dmi_req_data_o   (req_data),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_data_i  (resp_data),
        .dmi_resp_resp_i  (resp_resp),
        .dmi_rst_no       (rst_n_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge tck);
    endtask

    task automatic dtmcs_access(input logic [31:0] din, output logic [31:0] dout);
        dtmcs_select = 1'b1;
        capture      = 1'b1;
        cyc();
        capture = 1'b0;
        shift   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tdi     = din[i];
            dout[i] = dtmcs_tdo;
            cyc();
        end
        shift  = 1'b0;
        tdi    = 1'b0;
        update = 1'b1;
        cyc();
        update       = 1'b0;
        dtmcs_select = 1'b0;
    endtask

    task automatic dmi_access(input logic [40:0] din, output logic [40:0] dout);
        dmi_select = 1'b1;
        capture    = 1'b1;
        cyc();
        capture = 1'b0;
        shift   = 1'b1;
        for (int i = 0; i < 41; i++) begin
            tdi     = din[i];
            dout[i] = dmi_tdo;
            cyc();
        end
        shift  = 1'b0;
        tdi    = 1'b0;
        update = 1'b1;
        cyc();
        update     = 1'b0;
        dmi_select = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] resp);
        resp_valid = 1'b1;
        resp_data  = data;
        resp_resp  = resp;
        cyc();
        resp_valid = 1'b0;
        resp_resp  = 2'd0;
    endtask

    initial begin
        trst_n = 1'b0; dmi_clear = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
        tdi = 1'b0; dtmcs_select = 1'b0; dmi_select = 1'b0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0; resp_resp = '0;
        cyc(2);
        check("rst_req_valid", req_valid, 0);
        check("rst_resp_ready", resp_ready, 0);
        check("rst_rst_n", rst_n_out, 1);
        check("rst_tdo", {dtmcs_tdo, dmi_tdo}, 0);
        trst_n = 1'b1;
        cyc();

        dtmcs_access(32'h0, d32);
        check("dtmcs_reset_val", d32, 32'h0000_1071);

        // Write, ready arriving on the third valid cycle.
        dmi_access({7'h10, 32'hDEADBEEF, 2'd2}, d41);
        check("dmi_first_capture", d41, 0);
        for (int k = 0; k < 3; k++) begin
            check("wr_valid", req_valid, 1);
            check("wr_payload", {req_addr, req_op, req_data}, {7'h10, 2'd2, 32'hDEADBEEF});
            if (k == 2) req_ready = 1'b1;
            cyc();
        end
        req_ready = 1'b0;
        check("wr_valid_drop", req_valid, 0);
        check("wr_resp_ready", resp_ready, 1);
        respond(32'hCAFEF00D, 2'd0);
        check("wr_idle_resp_ready", resp_ready, 0);
        dmi_access(41'h0, d41);
        check("wr_capture_op", d41[1:0], 0);
        check("wr_capture_all", d41, {7'h10, 32'hDEADBEEF, 2'd0});

        // Read returning data.
        dmi_access({7'h11, 32'h0, 2'd1}, d41);
        check("rd_req", {req_valid, req_addr, req_op}, {1'b1, 7'h11, 2'd1});
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        respond(32'h12345678, 2'd0);
        dmi_access(41'h0, d41);
        check("rd_capture", d41, {7'h11, 32'h12345678, 2'd0});

        // Access while a read is outstanding -> sticky busy.
        dmi_access({7'h05, 32'h0, 2'd1}, d41);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        check("busy_waitread", resp_ready, 1);
        dmi_access({7'h30, 32'hFFFF0000, 2'd2}, d41);
        check("busy_capture_op", d41[1:0], 3);
        check("busy_capture_all", d41, {7'h05, 32'h0, 2'd3});
        check("busy_no_req", {req_valid, resp_ready}, 2'b01);
        respond(32'hAAAA5555, 2'd0);
        dtmcs_access(32'h0, d32);
        check("busy_dmistat", d32, 32'h0000_1C71);
        dmi_access({7'h22, 32'h0, 2'd1}, d41);
        check("busy_sticky_capture", d41, {7'h05, 32'hAAAA5555, 2'd3});
        check("busy_ignored", req_valid, 0);
        dtmcs_access(32'h0001_0000, d32);
        check("dmireset_capture", d32, 32'h0000_1C71);
        dtmcs_access(32'h0, d32);
        check("dmireset_cleared", d32, 32'h0000_1071);
        dmi_access({7'h22, 32'h0, 2'd1}, d41);
        check("post_reset_req", {req_valid, req_addr, req_op}, {1'b1, 7'h22, 2'd1});
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        respond(32'h0BADF00D, 2'd0);

        // Failed write leaves data_q alone and reports dmistat=2.
        dmi_access({7'h12, 32'h0000_0001, 2'd2}, d41);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        respond(32'hFFFF_FFFF, 2'd2);
        dtmcs_access(32'h0, d32);
        check("failed_dmistat", d32, 32'h0000_1871);
        dmi_access(41'h0, d41);
        check("failed_capture", d41, {7'h12, 32'h0000_0001, 2'd2});
        dtmcs_access(32'h0001_0000, d32);

        // Hard reset while Read is stalled on ready.
        dmi_access({7'h13, 32'h0, 2'd1}, d41);
        check("hr_valid_before", req_valid, 1);
        dtmcs_access(32'h0002_0000, d32);
        check("hr_valid_drop", req_valid, 0);
        check("hr_rst_low", rst_n_out, 0);
        cyc();
        check("hr_rst_high", rst_n_out, 1);
        resp_valid = 1'b1;
        #1;
        check("hr_no_late_resp", resp_ready, 0);
        resp_valid = 1'b0;
        cyc();
        dtmcs_access(32'h0, d32);
        check("hr_dtmcs", d32, 32'h0000_1071);

        // Asynchronous reset in WaitWrite.
        dmi_access({7'h14, 32'h0000_0055, 2'd2}, d41);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        check("trst_waitwrite", resp_ready, 1);
        trst_n = 1'b0;
        #1;
        check("trst_outputs", {req_valid, resp_ready, rst_n_out, dtmcs_tdo, dmi_tdo}, 5'b00100);
        cyc();
        trst_n = 1'b1;
        cyc();
        dmi_access(41'h0, d41);
        check("trst_capture", d41, 0);

        // Synchronous clear in WaitWrite.
        dmi_access({7'h15, 32'h0000_0066, 2'd2}, d41);
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        dmi_clear = 1'b1;
        cyc();
        dmi_clear = 1'b0;
        check("clear_outputs", {req_valid, resp_ready, rst_n_out, dtmcs_tdo, dmi_tdo}, 5'b00100);
        dmi_access(41'h0, d41);
        check("clear_capture", d41, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_jtag_dr_ctrl.md
Name: dmi_jtag_dr_ctrl

Overview:
- Debug Transport Module (DTM) data-register controller.
- Consumes the TAP's capture/shift/update strobes and DR selects, and implements the DTMCS and DMI data registers per debug spec 0.13.
- Sequences one DMI request/response transaction at a time towards the Debug Module over a valid/ready interface.
- Owns sticky error/busy reporting and dmireset/dmihardreset. Entirely in the TCK domain; any CDC is downstream.

Parameters:
- AbitsWidth, 7, DMI address width; reported in dtmcs.abits.
- IdleCycles, 3'd1, value reported in dtmcs.idle.

Ports:
- tck_i  in  1  JTAG test clock; all state on posedge.
- trst_ni  in  1  reset, asynchronous, active-low.
- dmi_clear_i  in  1  TAP Test-Logic-Reset; synchronous clear of all state to reset values.
- capture_i  in  1  TAP Capture-DR strobe.
- shift_i  in  1  TAP Shift-DR strobe.
- update_i  in  1  TAP Update-DR strobe.
- tdi_i  in  1  serial data in.
- dtmcs_select_i  in  1  DTMCS register selected.
- dtmcs_tdo_o  out  1  DTMCS shift register bit 0.
- dmi_select_i  in  1  DMI register selected.
- dmi_tdo_o  out  1  DMI shift register bit 0.
- dmi_req_valid_o  out  1  request valid.
- dmi_req_ready_i  in  1  request accepted.
- dmi_req_addr_o  out  AbitsWidth  request address.
- dmi_req_op_o  out  2  request op: 1=read, 2=write.
- dmi_req_data_o  out  32  write data.
- dmi_resp_valid_i  in  1  response valid.
- dmi_resp_ready_o  out  1  response accepted.
- dmi_resp_data_i  in  32  read data.
- dmi_resp_resp_i  in  2  response status: 0=ok, 2=failed, 3=busy.
- dmi_rst_no  out  1  active-low one-cycle pulse on dmihardreset.

Behaviour:
- Reset (trst_ni low, or dmi_clear_i high at a posedge):
  - All shift registers 0; addr_q=0, data_q=0, error_q=0; FSM=Idle.
  - dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_rst_no=1.
  - Both tdo outputs 0.
- DTMCS value: {14'b0, 1'b0 hardreset, 1'b0 dmireset, 1'b0, IdleCycles[2:0], error_q[1:0], AbitsWidth[5:0], 4'd1}.
- DTMCS register (when dtmcs_select_i):
  - capture_i loads the DTMCS value into a 32-bit shift register.
  - shift_i shifts right with tdi_i entering the MSB.
  - update_i decodes the shifted value:
    - bit16 set (dmireset): error_q=0.
    - bit17 set (dmihardreset): error_q=0, FSM->Idle, req_valid drops next cycle, dmi_rst_no=0 for exactly one cycle.
- DMI register, width AbitsWidth+34, layout {addr, data[31:0], op[1:0]}, LSB first (when dmi_select_i):
  - capture_i loads {addr_q, data_q, error_q}.
  - If FSM≠Idle at that capture, error_q is set to 3 (busy) and the captured op field is 3.
  - shift_i shifts right, tdi_i into the MSB.
  - update_i:
    - If FSM≠Idle: error_q=3; request ignored.
    - Else if error_q≠0: ignored.
    - Else latch addr_q, data_q from the shift register and decode op: 0 = no-op; 1 -> Read; 2 -> Write; 3 ignored.
- FSM states: Idle, Read, WaitRead, Write, WaitWrite.
  - Read/Write: dmi_req_valid_o=1 from the cycle after update_i; addr/op/data stable while valid. On valid&ready -> WaitRead/WaitWrite next cycle.
  - WaitRead/WaitWrite: dmi_resp_ready_o=1. On resp_valid -> Idle.
    - Read, resp 0: data_q=dmi_resp_data_i.
    - resp 2 or 3: error_q=resp. resp 1 maps to error_q=2.
    - Write: data_q is unchanged.
- Sticky error: error_q only becomes non-zero, never lower. It clears only via dmireset, dmihardreset or reset.
- Simultaneous events:
  - dmihardreset beats every FSM transition; a request handshaking in the same cycle is abandoned, and a late response is not accepted (resp_ready=0 in Idle).
  - A busy error set and dmireset in the same cycle cannot occur (different selects).
  - Capture and update never coincide (TAP guarantee); no priority needed.
- Both selects low: shift registers hold; tdo outputs reflect bit 0 regardless.

Decomposition:
- dmi_pkg holds:
  - dtm_op_e {DTM_NOP=0, DTM_READ=1, DTM_WRITE=2}
  - dtm_status_e {DTM_SUCCESS=0, DTM_RSVD=1, DTM_FAILED=2, DTM_BUSY=3}
  - packed struct dtmcs_t
  - DtmVersion=4'd1
  - dmi_req_t/dmi_resp_t structs.
- No sub-module: two shift registers and a 5-state FSM fit in one module.

Test Plan:
- DTMCS read after reset, shift 32 bits -> tdo sequence equals 32'h0000_1071 (AbitsWidth=7, idle=1, version=1), LSB first.
- DMI write addr=0x10, data=0xDEADBEEF, op=2; ready after 2 cycles, resp=0 -> req_valid high 1 cycle after update, held 3 cycles with stable payload; next capture op field reads 0.
- DMI read addr=0x11, DM returns data 0x12345678 resp 0 -> next capture shifts out {0x11, 0x12345678, 2'b00}.
- Second update while in WaitRead -> error_q=3, no second request; subsequent requests ignored; dmireset clears to 0 and the next read issues normally.
- resp=2 on write -> dtmcs.dmistat reads 2; dmihardreset while in Read with ready=0 -> req_valid low next cycle, dmi_rst_no low exactly 1 cycle, FSM Idle.
- trst_ni asserted mid-WaitWrite, and separately dmi_clear_i high -> all outputs at reset values, resp_ready 0.
